// File: rtl/reaction_interval_meter_if.sv
// Control and result bundle between the timer chain, the reaction meter and the score/display logic.
// master drives the events and ticks; slave is the meter that returns the measurement.
interface reaction_interval_meter_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 enable;
  logic                 tick_1ms;
  logic                 start;
  logic                 stop_evt;
  logic                 clear;
  logic                 busy;
  logic [CNT_WIDTH-1:0] elapsed_ms;
  logic                 result_valid;
  logic                 done_pulse;
  logic                 too_fast;
  logic                 timeout;

  modport master (
    output enable, tick_1ms, start, stop_evt, clear,
    input  busy, elapsed_ms, result_valid, done_pulse, too_fast, timeout
  );

  modport slave (
    input  enable, tick_1ms, start, stop_evt, clear,
    output busy, elapsed_ms, result_valid, done_pulse, too_fast, timeout
  );
endinterface

// File: rtl/reaction_interval_meter.sv
// Measures start-to-stop interval in 1 ms ticks.
// Flags each result as valid, too fast or timed out, and holds it until the next start or clear.
module reaction_interval_meter #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MAX_MS    = 9999,
  parameter int unsigned MIN_MS    = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  reaction_interval_meter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_MS);
  localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_MS);

  // Elaboration-time sanity of the threshold parameters
  if (64'(MAX_MS) >= (64'd1 << CNT_WIDTH)) begin : g_chk_max
    $error("reaction_interval_meter: MAX_MS does not fit in CNT_WIDTH");
  end
  if (MIN_MS > MAX_MS) begin : g_chk_min
    $error("reaction_interval_meter: MIN_MS exceeds MAX_MS");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 too_fast_q, too_fast_d;
  logic                 timeout_q, timeout_d;
  logic                 tick_ok;
  logic [CNT_WIDTH-1:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      too_fast_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      too_fast_q <= too_fast_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state and counter; priority clear > stop (RUN) > start > tick.
  // The counter register doubles as the latched result in DONE/TMO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;
    valid_d    = 1'b0;
    too_fast_d = 1'b0;
    timeout_d  = 1'b0;
    tick_ok    = bus.tick_1ms & bus.enable;
    cnt_inc    = cnt_q + CNT_WIDTH'(tick_ok);

    if (bus.clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          if (bus.stop_evt) begin
            // cnt_q < MAX_CNT in RUN, so cnt_inc never exceeds MAX_CNT
            state_d = ST_DONE;
            cnt_d   = cnt_inc;
            done_d  = 1'b1;
          end else if (bus.start) begin
            cnt_d = '0;
          end else if (tick_ok) begin
            if (cnt_inc == MAX_CNT) begin
              state_d = ST_TMO;
              done_d  = 1'b1;
            end
            cnt_d = cnt_inc;
          end
        end
        ST_DONE, ST_TMO: begin
          if (bus.start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d     = (state_d == ST_RUN);
    valid_d    = (state_d == ST_DONE) || (state_d == ST_TMO);
    timeout_d  = (state_d == ST_TMO);
    too_fast_d = (state_d == ST_DONE) && (cnt_d < MIN_CNT);
  end

  assign bus.busy         = busy_q;
  assign bus.elapsed_ms   = cnt_q;
  assign bus.result_valid = valid_q;
  assign bus.done_pulse   = done_q;
  assign bus.too_fast     = too_fast_q;
  assign bus.timeout      = timeout_q;

endmodule
